// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, R-type funct codes,
// multiplier FSM states and default datapath widths.
package ex_stage_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int REGW_DEF  = 3;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ADD2  = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    FUNCT_ADD = 3'b000,
    FUNCT_SUB = 3'b001,
    FUNCT_AND = 3'b010,
    FUNCT_OR  = 3'b011,
    FUNCT_SLT = 3'b100,
    FUNCT_SLL = 3'b101,
    FUNCT_MUL = 3'b110,
    FUNCT_NOR = 3'b111
  } funct_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/ex_multiplier.sv
// Iterative shift-add multiplier: one partial product per edge, WIDTH edges
// in BUSY, then a single DONE cycle in which the product is presented.
module ex_multiplier
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_e       state_r;
  mul_state_e       state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;

  // FSM state register; en low freezes the whole multiplier
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_r <= MUL_IDLE;
    end else if (en) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; BUSY leaves on the edge that brings the count to zero
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MUL_IDLE: begin
        if (start) state_nxt_s = MUL_BUSY;
        else       state_nxt_s = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (cnt_r == CW'(1)) state_nxt_s = MUL_DONE;
        else                 state_nxt_s = MUL_BUSY;
      end
      MUL_DONE: state_nxt_s = MUL_IDLE;
      default:  state_nxt_s = MUL_IDLE;
    endcase
  end

  // Shift-add datapath: operands latched on start, one step per BUSY edge
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
    end else if (en) begin
      case (state_r)
        MUL_IDLE: begin
          if (start) begin
            cnt_r    <= CW'(WIDTH);
            mcand_r  <= multiplicand;
            mplier_r <= multiplier;
            acc_r    <= {WIDTH{1'b0}};
          end
        end
        MUL_BUSY: begin
          if (mplier_r[0]) acc_r <= acc_r + mcand_r;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status decode and product output
  always_comb begin
    idle    = (state_r == MUL_IDLE);
    busy    = (state_r == MUL_BUSY);
    done    = (state_r == MUL_DONE);
    product = acc_r;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch-target adder, destination mux and EX/MEM
// register, with a multi-cycle multiplier that stalls the upstream stages.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REGW  = REGW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_in,
  input  logic [WIDTH-1:0] adder_in,
  input  logic [WIDTH-1:0] sign_extended_input,
  input  logic [WIDTH-1:0] regfile_read_data_1_in,
  input  logic [WIDTH-1:0] regfile_read_data_2_in,
  input  logic [REGW-1:0]  rt_in,
  input  logic [REGW-1:0]  rd_in,
  input  logic [1:0]       ALUOp_in,
  input  logic             RegDst_in,
  input  logic             ALUSrc_in,
  input  logic             MemToReg_in,
  input  logic             RegWrite_in,
  input  logic             MemRead_in,
  input  logic             MemWrite_in,
  input  logic             Branch_in,
  output logic [WIDTH-1:0] branch_target_out,
  output logic             zero_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] write_data_out,
  output logic [REGW-1:0]  write_reg_out,
  output logic             MemToReg_out,
  output logic             RegWrite_out,
  output logic             MemRead_out,
  output logic             MemWrite_out,
  output logic             Branch_out,
  output logic             stall_out
);

  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [WIDTH-1:0] ex_res_s;
  logic [WIDTH-1:0] product_s;
  funct_e           funct_s;
  logic             mul_req_s;
  logic             mul_idle_s;
  logic             mul_busy_s;
  logic             mul_done_s;

  // Operand select, funct decode and stall generation
  always_comb begin
    op_b_s    = ALUSrc_in ? sign_extended_input : regfile_read_data_2_in;
    funct_s   = funct_e'(sign_extended_input[2:0]);
    mul_req_s = (ALUOp_in == ALUOP_RTYPE) && (funct_s == FUNCT_MUL);
    stall_out = (mul_req_s && mul_idle_s) || mul_busy_s;
  end

  // ALU; the mul funct yields zero here because its result comes from the multiplier
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    case (ALUOp_in)
      ALUOP_SUB: alu_res_s = regfile_read_data_1_in - op_b_s;
      ALUOP_RTYPE: begin
        case (funct_s)
          FUNCT_ADD: alu_res_s = regfile_read_data_1_in + op_b_s;
          FUNCT_SUB: alu_res_s = regfile_read_data_1_in - op_b_s;
          FUNCT_AND: alu_res_s = regfile_read_data_1_in & op_b_s;
          FUNCT_OR:  alu_res_s = regfile_read_data_1_in | op_b_s;
          FUNCT_SLT: alu_res_s = {{(WIDTH-1){1'b0}},
                                  ($signed(regfile_read_data_1_in) < $signed(op_b_s))};
          FUNCT_SLL: alu_res_s = regfile_read_data_1_in << op_b_s[3:0];
          FUNCT_NOR: alu_res_s = ~(regfile_read_data_1_in | op_b_s);
          default:   alu_res_s = {WIDTH{1'b0}};
        endcase
      end
      default: alu_res_s = regfile_read_data_1_in + op_b_s;
    endcase
    ex_res_s = mul_done_s ? product_s : alu_res_s;
  end

  ex_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (hit_in),
    .start        (mul_req_s && mul_idle_s),
    .multiplicand (regfile_read_data_1_in),
    .multiplier   (op_b_s),
    .idle         (mul_idle_s),
    .busy         (mul_busy_s),
    .done         (mul_done_s),
    .product      (product_s)
  );

  // EX/MEM register: bubbles while stalled, data fields hold across a bubble
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      branch_target_out <= {WIDTH{1'b0}};
      zero_out          <= 1'b0;
      alu_result_out    <= {WIDTH{1'b0}};
      write_data_out    <= {WIDTH{1'b0}};
      write_reg_out     <= {REGW{1'b0}};
      MemToReg_out      <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemRead_out       <= 1'b0;
      MemWrite_out      <= 1'b0;
      Branch_out        <= 1'b0;
    end else if (hit_in) begin
      if (stall_out) begin
        MemToReg_out <= 1'b0;
        RegWrite_out <= 1'b0;
        MemRead_out  <= 1'b0;
        MemWrite_out <= 1'b0;
        Branch_out   <= 1'b0;
      end else begin
        branch_target_out <= adder_in + sign_extended_input;
        zero_out          <= (ex_res_s == {WIDTH{1'b0}});
        alu_result_out    <= ex_res_s;
        write_data_out    <= regfile_read_data_2_in;
        write_reg_out     <= RegDst_in ? rd_in : rt_in;
        MemToReg_out      <= MemToReg_in;
        RegWrite_out      <= RegWrite_in;
        MemRead_out       <= MemRead_in;
        MemWrite_out      <= MemWrite_in;
        Branch_out        <= Branch_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios with literal results,
// then randomized instructions checked every cycle against a behavioural model.
module tb_ex_stage;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n, hit_in;
  logic [15:0] adder_in, sign_extended_input, rd1, rd2;
  logic [2:0]  rt_in, rd_in;
  logic [1:0]  ALUOp_in;
  logic        RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
  logic [15:0] branch_target_out, alu_result_out, write_data_out;
  logic        zero_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, stall_out;
  logic [2:0]  write_reg_out;

  ex_stage #(.WIDTH(16), .REGW(3)) dut (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .adder_in(adder_in),
    .sign_extended_input(sign_extended_input),
    .regfile_read_data_1_in(rd1), .regfile_read_data_2_in(rd2),
    .rt_in(rt_in), .rd_in(rd_in), .ALUOp_in(ALUOp_in),
    .RegDst_in(RegDst_in), .ALUSrc_in(ALUSrc_in), .MemToReg_in(MemToReg_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .branch_target_out(branch_target_out), .zero_out(zero_out),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .write_reg_out(write_reg_out), .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Branch_out(Branch_out),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model: remaining edges of an in-flight multiply plus expected EX/MEM contents
  int          m_rem = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_prod, e_bt, e_res, e_wd;
  logic [2:0]  e_wr;
  logic        e_zero, e_m2r, e_rw, e_mr, e_mw, e_br;
  logic        dut_stall, mdl_stall = 1'b0, last_hit = 1'b1, last_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [2:0] f,
                                          input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    if (f == 3'd1) return a - b;
    if (f == 3'd2) return a & b;
    if (f == 3'd3) return a | b;
    if (f == 3'd4) return (sa < sb) ? 16'd1 : 16'd0;
    if (f == 3'd5) return a << b[3:0];
    if (f == 3'd7) return ~(a | b);
    return a + b;
  endfunction

  task automatic cycle();
    logic [15:0] b, r;
    logic [31:0] p;
    logic        req;
    #1;
    b   = ALUSrc_in ? sign_extended_input : rd2;
    req = (ALUOp_in == 2'b10) && (sign_extended_input[2:0] == 3'b110);
    mdl_stall = (m_rem > 1) || (m_rem == 0 && req);
    dut_stall = stall_out;
    last_hit  = hit_in;
    last_rst  = rst_n;
    if (m_valid) chk("stall", stall_out, mdl_stall);
    @(negedge clk);
    if (!rst_n) begin
      m_valid = 1'b1; m_rem = 0;
      {e_bt, e_res, e_wd} = '0; e_wr = '0;
      {e_zero, e_m2r, e_rw, e_mr, e_mw, e_br} = '0;
    end else if (hit_in) begin
      if (mdl_stall) begin
        if (m_rem == 0) begin
          p      = {16'h0, rd1} * {16'h0, b};
          m_prod = p[15:0];
          m_rem  = W + 1;
        end else begin
          m_rem--;
        end
        {e_m2r, e_rw, e_mr, e_mw, e_br} = '0;
      end else begin
        r      = (m_rem == 1) ? m_prod : ref_alu(ALUOp_in, sign_extended_input[2:0], rd1, b);
        m_rem  = 0;
        e_res  = r;
        e_zero = (r == 16'h0);
        e_bt   = adder_in + sign_extended_input;
        e_wd   = rd2;
        e_wr   = RegDst_in ? rd_in : rt_in;
        {e_m2r, e_rw, e_mr, e_mw, e_br} = {MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in};
      end
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("alu_result", alu_result_out, e_res);
      chk("zero", zero_out, e_zero);
      chk("branch_target", branch_target_out, e_bt);
      chk("write_data", write_data_out, e_wd);
      chk("write_reg", write_reg_out, e_wr);
      chk("ctrl", {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out},
          {e_m2r, e_rw, e_mr, e_mw, e_br});
    end
  endtask

  task automatic set_nop();
    adder_in = 16'h0; sign_extended_input = 16'h0; rd1 = 16'h0; rd2 = 16'h0;
    rt_in = 3'd0; rd_in = 3'd0; ALUOp_in = 2'b00;
    {RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in} = '0;
  endtask

  task automatic set_r(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    set_nop();
    ALUOp_in = 2'b10; sign_extended_input = {13'h0, f}; rd1 = a; rd2 = b;
    RegDst_in = 1'b1; rd_in = 3'd6; rt_in = 3'd2; RegWrite_in = 1'b1; adder_in = 16'h0040;
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int freeze_at,
                         output int stalls, output int bubbles, output int edges);
    logic finished = 1'b0;
    stalls = 0; bubbles = 0; edges = 0;
    set_r(3'b110, a, b);
    for (int i = 0; i < 60; i++) begin
      if (i == freeze_at) hit_in = 1'b0;
      if (i == freeze_at + 5) hit_in = 1'b1;
      cycle();
      edges++;
      if (dut_stall) begin
        stalls++;
        if (!RegWrite_out) bubbles++;
      end else begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) chk("mul_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int s, bb, e;
    rst_n = 1'b0; hit_in = 1'b1; set_nop();
    cycle(); cycle();
    chk("rst_result", alu_result_out, 16'h0);
    chk("rst_regwrite", RegWrite_out, 1'b0);
    rst_n = 1'b1;

    set_r(3'b001, 16'h0005, 16'h0005); cycle();
    chk("sub_result", alu_result_out, 16'h0000);
    chk("sub_zero", zero_out, 1'b1);
    set_r(3'b100, 16'hFFFF, 16'h0001); cycle();
    chk("slt_result", alu_result_out, 16'h0001);

    set_nop();
    ALUSrc_in = 1'b1; adder_in = 16'h0010; sign_extended_input = 16'hFFFC;
    rd1 = 16'h0100; rt_in = 3'd3; rd_in = 3'd5; RegWrite_in = 1'b1;
    cycle();
    chk("imm_result", alu_result_out, 16'h00FC);
    chk("imm_branch_target", branch_target_out, 16'h000C);
    chk("imm_write_reg", write_reg_out, 3'd3);

    run_mul(16'h0013, 16'h0007, -10, s, bb, e);
    chk("mul1_stall_len", s, 17);
    chk("mul1_bubbles", bb, 17);
    chk("mul1_edges", e, 18);
    chk("mul1_result", alu_result_out, 16'h0085);
    chk("mul1_regwrite", RegWrite_out, 1'b1);
    run_mul(16'hFFFF, 16'hFFFF, -10, s, bb, e);
    chk("mul2_stall_len", s, 17);
    chk("mul2_result", alu_result_out, 16'h0001);

    run_mul(16'h1234, 16'h0003, 6, s, bb, e);
    chk("freeze_edges", e, 23);
    chk("freeze_result", alu_result_out, 16'h369C);

    set_r(3'b110, 16'h00AA, 16'h0055);
    for (int i = 0; i < 5; i++) cycle();
    rst_n = 1'b0; set_nop();
    cycle(); cycle();
    rst_n = 1'b1;
    chk("rst_busy_result", alu_result_out, 16'h0);
    chk("rst_busy_ctrl", {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out}, 5'h0);
    #1;
    chk("rst_busy_stall", stall_out, 1'b0);
    cycle();

    set_r(3'b000, 16'h0001, 16'h0002); cycle();
    chk("pre_rst_result", alu_result_out, 16'h0003);
    rst_n = 1'b0; hit_in = 1'b0; cycle();
    chk("rst_hit_result", alu_result_out, 16'h0);
    chk("rst_hit_regwrite", RegWrite_out, 1'b0);
    rst_n = 1'b1; hit_in = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      if (!last_rst || (last_hit && !mdl_stall)) begin
        set_nop();
        ALUOp_in = 2'($urandom_range(0, 3));
        sign_extended_input = 16'($urandom);
        if (ALUOp_in == 2'b10 && $urandom_range(0, 3) == 0) sign_extended_input[2:0] = 3'b110;
        rd1 = 16'($urandom);
        rd2 = ($urandom_range(0, 5) == 0) ? rd1 : 16'($urandom);
        adder_in = 16'($urandom);
        rt_in = 3'($urandom); rd_in = 3'($urandom);
        {RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in} = 7'($urandom);
        if (ALUOp_in == 2'b10 && $urandom_range(0, 1) == 0) ALUSrc_in = 1'b0;
      end
      rst_n  = ($urandom_range(0, 99) != 0);
      hit_in = ($urandom_range(0, 7) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipelined MIPS core. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs.
- Contains the ALU, the branch-target adder, the destination-register mux and an iterative shift-add multiplier. Results are registered into EX/MEM outputs that feed the data-memory stage.
- Multiplies take several cycles. While one is in progress, stall_out freezes the upstream stages and EX/MEM receives bubbles.

Parameters:
- WIDTH, 16, datapath width and multiplier iteration count.
- REGW, 3, register-specifier width.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the other pipeline registers.
- rst_n  in  1  synchronous active-low reset, sampled on the same falling edge.
- hit_in  in  1  cache hit; 0 = global freeze, all state holds.
- adder_in  in  WIDTH  PC+1 from ID/EX.
- sign_extended_input  in  WIDTH  immediate; bits [2:0] are funct for R-type.
- regfile_read_data_1_in, regfile_read_data_2_in  in  WIDTH  operands A, B.
- rt_in, rd_in  in  REGW  register specifiers.
- ALUOp_in  in  2  00 add, 01 sub, 10 R-type (funct), 11 add.
- RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control.
- branch_target_out  out  WIDTH  adder_in + immediate.
- zero_out  out  1  ALU result == 0.
- alu_result_out  out  WIDTH  ALU or multiplier result.
- write_data_out  out  WIDTH  operand B, used for the store.
- write_reg_out  out  REGW  RegDst ? rd : rt.
- MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out  out  1 each  forwarded control.
- stall_out  out  1  combinational; holds IF/ID and ID/EX while high.

Behaviour:
- Operand B = ALUSrc_in ? sign_extended_input : regfile_read_data_2_in.
- funct codes under ALUOp 10: 000 add, 001 sub, 010 and, 011 or, 100 slt (signed; result 1 or 0), 101 sll A by B[3:0], 110 mul, 111 nor.
- All arithmetic is modulo 2^WIDTH; overflow is ignored.
- mul_req = ALUOp_in==10 && funct==110.
- Reset (rst_n=0 at an edge): all outputs 0, FSM goes to IDLE, counter 0. Reset overrides hit_in and aborts any multiply in progress.
- hit_in=0 and rst_n=1: FSM, counter, accumulator and all outputs hold; stall_out keeps its current value.
- FSM state IDLE:
  - Non-mul op: EX/MEM loads the results on every edge; latency 1 edge.
  - mul_req: stall_out=1. On the edge, latch multiplicand=A and multiplier=B, clear the accumulator, set cnt=WIDTH and go to BUSY. EX/MEM loads a bubble: RegWrite/MemRead/MemWrite/Branch/MemToReg = 0, data outputs hold.
- FSM state BUSY:
  - stall_out=1.
  - On each edge: if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt -= 1. EX/MEM loads a bubble.
  - When cnt reaches 0, go to DONE.
- FSM state DONE:
  - stall_out=0.
  - On the edge, EX/MEM loads alu_result=acc (low WIDTH bits, identical for signed and unsigned), zero=(acc==0), write_reg and control from the held ID/EX inputs. Go to IDLE.
  - Upstream advances on this same edge.
- Multiply stall length is WIDTH+1 cycles; the result reaches EX/MEM WIDTH+2 edges after the mul enters EX.
- A mul followed immediately by another mul: the second mul enters EX on the DONE edge and starts a fresh IDLE→BUSY sequence with no lost cycle.
- Branch resolution stays downstream: this block only produces branch_target_out, zero_out and Branch_out.

Decomposition:
- Shared package: ALUOp encodings, funct codes, FSM state encoding (IDLE/BUSY/DONE), WIDTH/REGW defaults.
- One sub-module, ex_multiplier: the shift-add FSM with start/busy/done/product interface. The ALU, muxes and EX/MEM registers stay in ex_stage.

Test Plan:
- Reset: rst_n=0 for 2 edges while a mul is in BUSY → all outputs 0 and stall_out=0 in the cycle after reset is released.
- ALU: ALUOp=10, funct=001, A=0x0005, B=0x0005 → alu_result_out=0x0000, zero_out=1 after 1 edge. funct=100, A=0xFFFF, B=0x0001 → result 0x0001.
- Branch/immediate: ALUSrc=1, adder_in=0x0010, imm=0xFFFC, ALUOp=00, A=0x0100 → alu_result_out=0x00FC, branch_target_out=0x000C; RegDst=0, rt=3 → write_reg_out=3.
- Multiply: A=0x0013, B=0x0007, funct=110, RegWrite=1 → stall_out high exactly 17 cycles; bubbles (RegWrite_out=0) for 17 edges; then alu_result_out=0x0085, RegWrite_out=1. Back-to-back second mul 0xFFFF×0xFFFF → 0x0001.
- Freeze: drop hit_in for 5 cycles mid-BUSY → cnt, acc and outputs unchanged; the product is still correct and arrives 5 edges later.
- Reset vs hit: rst_n=0 with hit_in=0 → outputs still cleared on that edge.
